// File: rtl/ccir656_rx.sv
// ccir656_rx: BT.656 byte-stream receiver.
//
// Tracks the embedded FF 00 00 XY timing reference codes in an interleaved
// Cb Y Cr Y byte stream and emits one {Y, Cb, Cr} triple per active pixel.
//
// Handshake: data_valid_i qualifies data_i for one cycle. There is no ready
// signal. pix_valid_o is a one-cycle strobe that the downstream stage must
// accept in the same cycle; throttle data_valid_i upstream if it cannot.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   data_i         BT.656 byte
//   data_valid_i   byte qualifier; with it low, all state holds
//   Y_data         luma of the emitted pixel
//   Cb_data        Cb of the emitted pixel
//   Cr_data        Cr of the emitted pixel
//   pix_valid_o    one-cycle pixel strobe
//   line_start_o   one-cycle pulse on each SAV with V=0
//   frame_start_o  one-cycle pulse on the first V=0/F=0 SAV after a V=1 code
//   field_o        F bit of the last accepted code
//   vblank_o       V bit of the last accepted code
//   hblank_o       high outside active video
//   prot_err_o     one-cycle pulse on a protection or preamble error
module ccir656_rx #(
  parameter int ACTIVE_WIDTH = 720,
  parameter bit CHECK_PROT   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic [7:0] Y_data,
  output logic [7:0] Cb_data,
  output logic [7:0] Cr_data,
  output logic       pix_valid_o,
  output logic       line_start_o,
  output logic       frame_start_o,
  output logic       field_o,
  output logic       vblank_o,
  output logic       hblank_o,
  output logic       prot_err_o
);

  localparam int CW = $clog2(ACTIVE_WIDTH + 1);

  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    PRE1   = 3'd1,
    PRE2   = 3'd2,
    PRE3   = 3'd3,
    ACTIVE = 3'd4
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  logic [1:0]    phase;
  logic [CW-1:0] pix_cnt;
  logic [7:0]    cb_hold;
  logic [7:0]    y0_hold;
  logic [7:0]    cr_hold;
  // Set by any accepted code with V=1; the next V=0/F=0 SAV fires frame_start.
  // Reset arms it so the first field after reset is reported as a new frame.
  logic          frame_armed;

  // XY decode of the byte currently on data_i (only meaningful in PRE3).
  logic xy_f, xy_v, xy_h;
  logic xy_prot_ok, xy_ok;
  logic can_emit;

  assign xy_f       = data_i[6];
  assign xy_v       = data_i[5];
  assign xy_h       = data_i[4];
  assign xy_prot_ok = (data_i[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v,
                                       xy_f ^ xy_v ^ xy_h});
  assign xy_ok      = data_i[7] && (xy_prot_ok || !CHECK_PROT);
  // Counter saturates at ACTIVE_WIDTH; bytes past that are consumed silently.
  assign can_emit   = (pix_cnt < CW'(ACTIVE_WIDTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= BLANK;
      phase         <= 2'd0;
      pix_cnt       <= '0;
      cb_hold       <= 8'h00;
      y0_hold       <= 8'h00;
      cr_hold       <= 8'h00;
      frame_armed   <= 1'b1;
      Y_data        <= 8'h00;
      Cb_data       <= 8'h00;
      Cr_data       <= 8'h00;
      pix_valid_o   <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      field_o       <= 1'b0;
      vblank_o      <= 1'b1;
      hblank_o      <= 1'b1;
      prot_err_o    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, even across data_valid_i gaps.
      pix_valid_o   <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      prot_err_o    <= 1'b0;

      if (data_valid_i) begin
        case (state)
          BLANK: begin
            if (data_i == 8'hFF) state <= PRE1;
          end

          PRE1: begin
            if (data_i == 8'h00) begin
              state <= PRE2;
            end else begin
              state      <= BLANK;
              prot_err_o <= 1'b1;
            end
          end

          PRE2: begin
            if (data_i == 8'h00) begin
              state <= PRE3;
            end else begin
              state      <= BLANK;
              prot_err_o <= 1'b1;
            end
          end

          PRE3: begin
            if (!xy_ok) begin
              // Rejected code: flags keep their previous values.
              prot_err_o <= 1'b1;
              state      <= BLANK;
            end else begin
              field_o  <= xy_f;
              vblank_o <= xy_v;
              if (xy_v) frame_armed <= 1'b1;
              if (xy_h) hblank_o <= 1'b1;
              if (xy_h || xy_v) begin
                // EAV, or SAV inside vertical blanking: no payload is decoded.
                state <= BLANK;
              end else begin
                state        <= ACTIVE;
                phase        <= 2'd0;
                pix_cnt      <= '0;
                line_start_o <= 1'b1;
                hblank_o     <= 1'b0;
                if (frame_armed && !xy_f) begin
                  frame_start_o <= 1'b1;
                  frame_armed   <= 1'b0;
                end
              end
            end
          end

          ACTIVE: begin
            if (data_i == 8'hFF) begin
              // Start of the next timing code; any partial group is dropped
              // because the phase restarts at the next SAV.
              state    <= PRE1;
              hblank_o <= 1'b1;
            end else begin
              phase <= phase + 2'd1;
              case (phase)
                2'd0: cb_hold <= data_i;
                2'd1: y0_hold <= data_i;
                2'd2: begin
                  cr_hold <= data_i;
                  if (can_emit) begin
                    pix_valid_o <= 1'b1;
                    Y_data      <= y0_hold;
                    Cb_data     <= cb_hold;
                    Cr_data     <= data_i;
                    pix_cnt     <= pix_cnt + 1'b1;
                  end
                end
                default: begin
                  if (can_emit) begin
                    pix_valid_o <= 1'b1;
                    Y_data      <= data_i;
                    Cb_data     <= cb_hold;
                    Cr_data     <= cr_hold;
                    pix_cnt     <= pix_cnt + 1'b1;
                  end
                end
              endcase
            end
          end

          default: state <= BLANK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccir656_rx.sv
// tb_ccir656_rx: self-checking bench for ccir656_rx.
//
// Stimulus is described line by line (timing codes, payload, blanking); a
// reference model turns each line description into the per-cycle response it
// must produce, and every driven cycle is checked against that expectation.
module tb_ccir656_rx;

  localparam int W = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data_i;
  logic       data_valid_i;
  logic [7:0] y_data, cb_data, cr_data;
  logic       pix_valid, line_start, frame_start, field, vblank, hblank, prot_err;

  ccir656_rx #(.ACTIVE_WIDTH(W), .CHECK_PROT(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .Y_data       (y_data),
    .Cb_data      (cb_data),
    .Cr_data      (cr_data),
    .pix_valid_o  (pix_valid),
    .line_start_o (line_start),
    .frame_start_o(frame_start),
    .field_o      (field),
    .vblank_o     (vblank),
    .hblank_o     (hblank),
    .prot_err_o   (prot_err)
  );

  // ---------------------------------------------------------------- scoreboard
  // One entry per driven cycle: the byte driven and the response expected on
  // the following cycle.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pv;
    logic [7:0] y, cb, cr;
    logic       ls, fs, pe, fld, vb, hb;
  } step_t;

  step_t       sq[$];
  logic [23:0] exp_q[$];   // every expected pixel {Y, Cb, Cr}, in order
  step_t       prev;
  bit          have_prev = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_seen_pix = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_step(input step_t e);
    logic [23:0] px;
    check_eq("pix_valid", 32'(pix_valid), 32'(e.pv));
    if (e.pv) begin
      px = (exp_q.size() != 0) ? exp_q.pop_front() : 24'h0;
      check_eq("pixel_yuv", 32'({y_data, cb_data, cr_data}), 32'(px));
    end
    if (pix_valid) n_seen_pix++;
    check_eq("line_start", 32'(line_start), 32'(e.ls));
    check_eq("frame_start", 32'(frame_start), 32'(e.fs));
    check_eq("prot_err", 32'(prot_err), 32'(e.pe));
    check_eq("field", 32'(field), 32'(e.fld));
    check_eq("vblank", 32'(vblank), 32'(e.vb));
    check_eq("hblank", 32'(hblank), 32'(e.hb));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".yuv"}, 32'({y_data, cb_data, cr_data}), 32'h0);
    check_eq({tag, ".pulses"}, 32'({pix_valid, line_start, frame_start, prot_err}), 32'h0);
    check_eq({tag, ".field"}, 32'(field), 32'h0);
    check_eq({tag, ".vblank"}, 32'(vblank), 32'h1);
    check_eq({tag, ".hblank"}, 32'(hblank), 32'h1);
  endtask

  // ---------------------------------------------------------------- reference model
  bit          m_field, m_vb, m_hb, m_armed, m_active;
  logic [7:0]  lb[$];      // payload bytes of the current active line
  int          npix;
  int          n_exp_pix = 0;

  task automatic model_reset();
    m_field  = 1'b0;
    m_vb     = 1'b1;
    m_hb     = 1'b1;
    m_armed  = 1'b1;
    m_active = 1'b0;
    lb.delete();
    npix     = 0;
  endtask

  function automatic logic [7:0] mk_xy(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] rand_nonff();
    return 8'($urandom_range(0, 254));
  endfunction

  task automatic push(input logic [7:0] d, input logic pv, input logic [23:0] px,
                      input logic ls, input logic fs, input logic pe);
    step_t s;
    s.v = 1'b1; s.d = d; s.pv = pv;
    s.y = px[23:16]; s.cb = px[15:8]; s.cr = px[7:0];
    s.ls = ls; s.fs = fs; s.pe = pe;
    s.fld = m_field; s.vb = m_vb; s.hb = m_hb;
    sq.push_back(s);
    if (pv) begin
      exp_q.push_back(px);
      n_exp_pix++;
    end
  endtask

  // A non-FF byte. Inside an active line, the byte at position i of the
  // payload completes a pixel when i%4 is 2 (Y0) or 3 (Y1), while fewer than
  // W pixels have been produced on this line.
  task automatic m_data(input logic [7:0] d);
    int i;
    if (!m_active) begin
      push(d, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    end else begin
      lb.push_back(d);
      i = lb.size() - 1;
      if (i % 4 == 2 && npix < W) begin
        npix++;
        push(d, 1'b1, {lb[i-1], lb[i-2], d}, 1'b0, 1'b0, 1'b0);
      end else if (i % 4 == 3 && npix < W) begin
        npix++;
        push(d, 1'b1, {d, lb[i-3], lb[i-1]}, 1'b0, 1'b0, 1'b0);
      end else begin
        push(d, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic m_ff();
    if (m_active) begin
      m_active = 1'b0;
      m_hb     = 1'b1;
    end
    push(8'hFF, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic m_code(input logic [7:0] xy);
    bit f, v, h, ls, fs;
    m_ff();
    push(8'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    push(8'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    f = xy[6]; v = xy[5]; h = xy[4];
    if (!(xy[7] && xy == mk_xy(f, v, h))) begin
      push(xy, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    end else begin
      m_field = f;
      m_vb    = v;
      if (v) m_armed = 1'b1;
      ls = 1'b0;
      fs = 1'b0;
      if (!h && !v) begin
        ls = 1'b1;
        fs = m_armed && !f;
        if (fs) m_armed = 1'b0;
        m_hb     = 1'b0;
        m_active = 1'b1;
        lb.delete();
        npix     = 0;
      end
      push(xy, 1'b0, 24'h0, ls, fs, 1'b0);
    end
  endtask

  // FF followed by a broken preamble (FF x or FF 00 x, x neither 00 nor FF).
  task automatic m_bad_pre();
    m_ff();
    if ($urandom_range(0, 1) == 1) push(8'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    push(8'($urandom_range(1, 254)), 1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic m_fill(input int n);
    repeat (n) m_data(rand_nonff());
  endtask

  // ---------------------------------------------------------------- driver
  function automatic step_t idle_of(input step_t s);
    step_t g;
    g    = s;
    g.v  = 1'b0;
    g.d  = 8'($urandom_range(0, 255));
    g.pv = 1'b0; g.ls = 1'b0; g.fs = 1'b0; g.pe = 1'b0;
    return g;
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    if (have_prev) check_step(prev);
    data_i       = s.d;
    data_valid_i = s.v;
    prev         = s;
    have_prev    = 1'b1;
  endtask

  task automatic run_steps(input int gap_pct);
    step_t s;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      if ($urandom_range(0, 99) < gap_pct)
        repeat ($urandom_range(1, 3)) drive(idle_of(prev));
      drive(s);
    end
    drive(idle_of(prev));
  endtask

  task automatic random_line();
    bit f;
    f = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0, 1, 2: begin
        m_code(mk_xy(f, 1'b0, 1'b0));
        m_fill($urandom_range(0, 14));
        if ($urandom_range(0, 3) == 0) m_bad_pre();
        else m_code(mk_xy(f, 1'b0, 1'b1));
      end
      3: begin
        m_code(mk_xy(f, 1'b1, 1'b0));
        m_fill($urandom_range(0, 10));
        m_code(mk_xy(f, 1'b1, 1'b1));
      end
      4: m_code(mk_xy(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)))
                ^ 8'(8'h01 << $urandom_range(0, 7)));
      default: m_bad_pre();
    endcase
    m_fill($urandom_range(0, 4));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    data_i       = 8'h00;
    data_valid_i = 1'b0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    model_reset();
    prev      = idle_of(prev);
    prev.fld  = m_field; prev.vb = m_vb; prev.hb = m_hb;
    have_prev = 1'b1;

    // First SAV after reset with a single Cb Y Cr Y group.
    m_code(8'h80);
    m_data(8'h10); m_data(8'h20); m_data(8'h30); m_data(8'h40);
    // Full line longer than W: only W pixels, hblank rises on the FF.
    m_code(8'h80);
    m_fill(12);
    m_code(8'h9D);
    run_steps(0);

    // Corrupted XY code followed by bytes that must not produce pixels.
    m_code(8'h81);
    m_fill(8);
    run_steps(0);

    // Vertical blanking SAV, then frame start only on the first V=0 SAV.
    m_code(8'hAB);
    m_fill(8);
    m_code(mk_xy(1'b0, 1'b1, 1'b1));
    m_code(8'h80); m_fill(4); m_code(8'h9D);
    m_code(8'h80); m_fill(4); m_code(8'h9D);
    run_steps(0);

    // Gap of three idle cycles between Cb and Y0.
    m_code(8'h80);
    m_data(8'h11);
    run_steps(0);
    repeat (2) drive(idle_of(prev));
    m_data(8'h22); m_data(8'h33); m_data(8'h44);
    m_code(8'h9D);
    run_steps(0);

    // Asynchronous reset mid-line after the Y0 byte.
    m_code(8'h80);
    m_data(8'h55); m_data(8'h66);
    run_steps(0);
    @(negedge clk);
    check_step(prev);
    data_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev     = idle_of(prev);
    prev.fld = m_field; prev.vb = m_vb; prev.hb = m_hb;
    m_fill(6);
    m_code(8'h80); m_fill(4); m_code(8'h9D);
    run_steps(0);

    // Randomized lines with random idle gaps.
    repeat (150) begin
      random_line();
      run_steps(15);
    end

    @(negedge clk);
    check_step(prev);
    check_eq("pix_total", 32'(n_seen_pix), 32'(n_exp_pix));
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccir656_rx.md
# ccir656_rx

CCIR-656 (BT.656) byte-stream receiver that sits directly upstream of the YCbCr-to-RGB converter. It takes the 8-bit interleaved stream Cb Y Cr Y … and tracks the embedded FF 00 00 XY timing codes (SAV/EAV). It emits one {Y, Cb, Cr} triple per active pixel with a single-cycle strobe, together with field, blanking, line-start and frame-start flags.

## Interface

Parameters:
- ACTIVE_WIDTH, 720: active pixels per line. Pixels beyond this count before EAV are dropped.
- CHECK_PROT, 1: when 1, the XY protection bits P3..P0 are checked and bad codes are rejected.

Ports:
- clk_i  in  1  the single clock; all logic is on its rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- data_i  in  8  BT.656 byte.
- data_valid_i  in  1  qualifies data_i. Bytes with data_valid_i=0 are ignored and all state holds.
- Y_data  out  8  luma of the current pixel.
- Cb_data  out  8  Cb of the current pixel.
- Cr_data  out  8  Cr of the current pixel.
- pix_valid_o  out  1  one-cycle strobe; the Y/Cb/Cr outputs are valid while it is high.
- line_start_o  out  1  one-cycle pulse on every SAV with V=0.
- frame_start_o  out  1  one-cycle pulse on the first SAV with V=0 and F=0 after any code with V=1.
- field_o  out  1  F bit of the last accepted code.
- vblank_o  out  1  V bit of the last accepted code.
- hblank_o  out  1  high outside active video.
- prot_err_o  out  1  one-cycle pulse when a protection or sequence error is detected.

## Operation

- State machine states: BLANK, PRE1 (FF seen), PRE2 (FF 00 seen), PRE3 (FF 00 00 seen), ACTIVE.
- BLANK:
  - 0xFF → PRE1.
  - Any other byte → stay in BLANK.
- PRE1:
  - 0x00 → PRE2.
  - Any other byte → BLANK with prot_err_o.
- PRE2:
  - 0x00 → PRE3.
  - Any other byte → BLANK with prot_err_o.
- PRE3: the byte is XY = {1, F, V, H, P3, P2, P1, P0}.
  - Expected protection bits: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - Bit7=0, or a protection mismatch while CHECK_PROT=1 → prot_err_o, flags unchanged, go to BLANK.
  - Valid code → field_o<=F and vblank_o<=V.
  - H=1 (EAV) → BLANK.
  - H=0 with V=1 → BLANK; no pixels are emitted during vertical blanking.
  - H=0 with V=0 → ACTIVE. Clear the phase and the pixel counter, pulse line_start_o, pulse frame_start_o if its condition holds, drop hblank_o.
- ACTIVE: a 2-bit phase counter steps 0:Cb, 1:Y0, 2:Cr, 3:Y1, then wraps to 0.
  - Cb and Y0 are captured into holding registers.
  - On the Cr byte: emit pixel {Y0, Cb, Cr}.
  - On the Y1 byte: emit pixel {Y1, Cb, Cr}.
  - Each emit increments the pixel counter. When the counter reaches ACTIVE_WIDTH, further bytes are accepted but not emitted.
  - 0xFF in ACTIVE → PRE1, raise hblank_o, abandon any partial Cb/Y0 group. The FF byte is never emitted.
- Arithmetic: pure byte routing, no conversion. The pixel counter is $clog2(ACTIVE_WIDTH+1) bits wide and saturates.
- There is no backpressure. The downstream stage must accept one pixel per cycle, or the integrator must throttle data_valid_i.

## Timing

- Reset values (asynchronous): state BLANK; all data outputs 0x00; pix_valid_o, line_start_o, frame_start_o, prot_err_o = 0; field_o=0; vblank_o=1; hblank_o=1; phase and pixel counter 0.
- Latency: a pixel appears one cycle after its Cr or Y1 byte is sampled. pix_valid_o pulses in consecutive cycles for back-to-back Cr and Y1 bytes.
- line_start_o and frame_start_o are asserted the cycle after the XY byte, together with the hblank_o fall.
- A gap in data_valid_i mid-group holds phase and holding registers; the next valid byte continues the sequence.
- When rst_i is asserted mid-line, outputs go to their reset values immediately and no pixel is emitted until the next valid SAV.
- The H=1 EAV byte raises hblank_o the cycle after it is sampled. This is redundant with the FF-triggered raise.

## Test plan

- Reset, then FF 00 00 80 (SAV, F=0, V=0, H=0) and bytes 10 20 30 40 → frame_start_o and line_start_o each pulse once; pixels {Y=20,Cb=10,Cr=30} and {Y=40,Cb=10,Cr=30} appear one cycle after the 30 and 40 bytes respectively.
- Full line at ACTIVE_WIDTH=4: SAV, 12 payload bytes, EAV FF 00 00 9D → exactly 4 pixel strobes; hblank_o goes high after the FF byte.
- Corrupted XY 0x81 with CHECK_PROT=1 → prot_err_o pulses; no line_start_o; field_o and vblank_o keep their prior values; no pixels emitted.
- SAV during vertical blanking (XY=0xAB: F=0, V=1, H=0) followed by payload → vblank_o=1 and zero pixel strobes. The next 0x80 SAV pulses frame_start_o; a further 0x80 line does not.
- data_valid_i low for 3 cycles between Cb and Y0 → same pixel values as the gap-free case, delayed by 3 cycles.
- rst_i asserted after the Y0 byte of a line, then released while payload continues → all outputs at reset values and no pixels emitted until the next SAV.
